// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Holds the tag/valid/dirty state and sequences the external line-wide data RAM and the memory bus.
module dcache_ctrl #(
  parameter int CACHE_S    = 6,
  parameter int CACHE_B    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_W     = 8 * (2 ** CACHE_B)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_addr_ok,
  output logic                  cpu_data_ok,
  output logic [31:0]           cpu_rdata,
  output logic [CACHE_S-1:0]    ram_index,
  output logic [CACHE_B-3:0]    ram_offset,
  output logic [1:0]            ram_bit_pos,
  output logic [1:0]            ram_size,
  output logic [LINE_W-1:0]     ram_din,
  output logic                  ram_wen,
  input  logic [LINE_W-1:0]     ram_rdata,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic                  mem_rd_valid,
  input  logic [31:0]           mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [LINE_W-1:0]     mem_wr_data,
  input  logic                  mem_wr_ready,
  input  logic                  mem_wr_done
);

  localparam int TAG_W = ADDR_WIDTH - CACHE_S - CACHE_B;
  localparam int OFF_W = CACHE_B - 2;
  localparam int WORDS = 2 ** OFF_W;
  localparam int LINES = 2 ** CACHE_S;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WB_REQ  = 3'd2,
    WB_WAIT = 3'd3,
    RF_REQ  = 3'd4,
    RF_WAIT = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   req_addr_r;
  logic                    req_wr_r;
  logic [1:0]              req_size_r;
  logic [31:0]             req_wdata_r;
  logic [TAG_W-1:0]        tag_r [0:LINES-1];
  logic [LINES-1:0]        valid_r;
  logic [LINES-1:0]        dirty_r;
  logic [OFF_W-1:0]        cnt_r;

  logic [CACHE_S-1:0]      req_idx_s;
  logic [TAG_W-1:0]        req_tag_s;
  logic [OFF_W-1:0]        req_off_s;
  logic [OFF_W+4:0]        word_sel_s;
  logic [31:0]             old_word_s;
  logic                    hit_s;
  logic                    accept_s, set_dirty_s, clr_dirty_s, clr_valid_s, fill_done_s;
  logic                    cnt_clr_s, cnt_inc_s;

  // Replace the byte lanes addressed by a store, keeping the rest of the old word.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = old_w;
    case (size)
      2'b00:   m[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign req_idx_s  = req_addr_r[CACHE_B +: CACHE_S];
  assign req_tag_s  = req_addr_r[ADDR_WIDTH-1 -: TAG_W];
  assign req_off_s  = req_addr_r[2 +: OFF_W];
  assign word_sel_s = {req_off_s, 5'b00000};
  assign old_word_s = ram_rdata[word_sel_s +: 32];
  assign hit_s      = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);

  // Next-state and output decode; everything is held at zero while reset is asserted.
  always_comb begin
    state_s     = state_r;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = 32'h0000_0000;
    ram_index   = '0;
    ram_offset  = '0;
    ram_bit_pos = 2'b00;
    ram_size    = 2'b00;
    ram_din     = '0;
    ram_wen     = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    mem_wr_req  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    accept_s    = 1'b0;
    set_dirty_s = 1'b0;
    clr_dirty_s = 1'b0;
    clr_valid_s = 1'b0;
    fill_done_s = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    if (reset) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          cpu_addr_ok = cpu_req;
          if (cpu_req) begin
            accept_s = 1'b1;
            state_s  = LOOKUP;
          end else begin
            state_s  = IDLE;
          end
        end
        LOOKUP: begin
          ram_index  = req_idx_s;
          ram_offset = req_off_s;
          if (hit_s) begin
            cpu_data_ok = 1'b1;
            state_s     = IDLE;
            if (req_wr_r) begin
              ram_wen     = 1'b1;
              ram_size    = 2'b10;
              ram_bit_pos = req_addr_r[1:0];
              ram_din     = {WORDS{merge_word(old_word_s, req_wdata_r, req_size_r, req_addr_r[1:0])}};
              set_dirty_s = 1'b1;
            end else begin
              cpu_rdata   = old_word_s;
            end
          end else if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
            state_s = WB_REQ;
          end else begin
            clr_valid_s = 1'b1;
            state_s     = RF_REQ;
          end
        end
        WB_REQ: begin
          // Index stays on the victim so the RAM keeps presenting the same line.
          ram_index   = req_idx_s;
          mem_wr_req  = 1'b1;
          mem_wr_addr = {tag_r[req_idx_s], req_idx_s, {CACHE_B{1'b0}}};
          mem_wr_data = ram_rdata;
          if (mem_wr_ready) begin
            state_s = WB_WAIT;
          end else begin
            state_s = WB_REQ;
          end
        end
        WB_WAIT: begin
          if (mem_wr_done) begin
            clr_dirty_s = 1'b1;
            clr_valid_s = 1'b1;
            state_s     = RF_REQ;
          end else begin
            state_s     = WB_WAIT;
          end
        end
        RF_REQ: begin
          mem_rd_req  = 1'b1;
          mem_rd_addr = {req_tag_s, req_idx_s, {CACHE_B{1'b0}}};
          if (mem_rd_ready) begin
            cnt_clr_s = 1'b1;
            state_s   = RF_WAIT;
          end else begin
            state_s   = RF_REQ;
          end
        end
        RF_WAIT: begin
          ram_index  = req_idx_s;
          ram_offset = cnt_r;
          if (mem_rd_valid) begin
            ram_wen   = 1'b1;
            ram_size  = 2'b10;
            ram_din   = {WORDS{mem_rd_data}};
            cnt_inc_s = 1'b1;
            if (cnt_r == OFF_W'(WORDS - 1)) begin
              fill_done_s = 1'b1;
              state_s     = LOOKUP;
            end else begin
              state_s     = RF_WAIT;
            end
          end else begin
            state_s = RF_WAIT;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request register, loaded on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_r  <= '0;
      req_wr_r    <= 1'b0;
      req_size_r  <= 2'b00;
      req_wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      req_addr_r  <= cpu_addr;
      req_wr_r    <= cpu_wr;
      req_size_r  <= cpu_size;
      req_wdata_r <= cpu_wdata;
    end
  end

  // Valid and dirty bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else begin
      if (clr_valid_s) begin
        valid_r[req_idx_s] <= 1'b0;
      end else if (fill_done_s) begin
        valid_r[req_idx_s] <= 1'b1;
      end
      if (set_dirty_s) begin
        dirty_r[req_idx_s] <= 1'b1;
      end else if (clr_dirty_s || fill_done_s) begin
        dirty_r[req_idx_s] <= 1'b0;
      end
    end
  end

  // Tag array, written when a refill completes.
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      tag_r[req_idx_s] <= req_tag_s;
    end
  end

  // Refill beat counter.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr_s) begin
      cnt_r <= '0;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + OFF_W'(1);
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural line RAM, scripted memory-bus responder, hand-computed expectations.
module tb_dcache_ctrl;

  logic         clk, reset;
  logic         cpu_req, cpu_wr;
  logic [1:0]   cpu_size;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_addr_ok, cpu_data_ok;
  logic [31:0]  cpu_rdata;
  logic [5:0]   ram_index;
  logic [1:0]   ram_offset, ram_bit_pos, ram_size;
  logic [127:0] ram_din, ram_rdata;
  logic         ram_wen;
  logic         mem_rd_req, mem_rd_ready, mem_rd_valid;
  logic [31:0]  mem_rd_addr, mem_rd_data;
  logic         mem_wr_req, mem_wr_ready, mem_wr_done;
  logic [31:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;

  dcache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .ram_index(ram_index), .ram_offset(ram_offset), .ram_bit_pos(ram_bit_pos), .ram_size(ram_size),
    .ram_din(ram_din), .ram_wen(ram_wen), .ram_rdata(ram_rdata),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .mem_wr_done(mem_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line-wide data RAM with combinational read and word-granular write.
  logic [127:0] ram_mem [0:63];
  assign ram_rdata = ram_mem[ram_index];
  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_index][{ram_offset, 5'b00000} +: 32] <= ram_din[{ram_offset, 5'b00000} +: 32];
  end

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus responder state and observations.
  logic [31:0]  rf_data [4];
  int           rd_phase = 0, rd_beat = 0, rd_limit = 4, rd_req_cnt = 0;
  int           wr_phase = 0, wr_wait = 0, wr_delay = 0, wr_req_cnt = 0;
  int           order_err = 0, stable_err = 0, dok_cnt = 0;
  logic [31:0]  last_rd_addr = 32'h0, last_wr_addr = 32'h0;
  logic [127:0] last_wr_data = 128'h0;

  initial begin
    mem_rd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 32'h0;
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      mem_rd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 32'h0;
      mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
      if (reset) begin
        rd_phase = 0; wr_phase = 0;
      end else begin
        if (rd_phase == 1) begin rd_phase = 2; rd_beat = 0; end
        if (rd_phase == 2) begin
          if (rd_beat < rd_limit) begin
            mem_rd_valid = 1'b1; mem_rd_data = rf_data[rd_beat]; rd_beat++;
          end else if (rd_beat >= 4) rd_phase = 0;
        end
        if (rd_phase == 0 && mem_rd_req) begin
          mem_rd_ready = 1'b1; rd_req_cnt++; last_rd_addr = mem_rd_addr;
          if (wr_phase != 0) order_err++;
          rd_phase = 1;
        end
        if (wr_phase == 3) begin
          if (wr_wait == 2) begin mem_wr_done = 1'b1; wr_phase = 0; end
          else wr_wait++;
        end else if (wr_phase == 2) begin
          wr_phase = 3; wr_wait = 0;
        end
        if (wr_phase == 0 && mem_wr_req) begin
          last_wr_addr = mem_wr_addr; last_wr_data = mem_wr_data; wr_req_cnt++;
          wr_phase = 1; wr_wait = 0;
        end
        if (wr_phase == 1) begin
          if (!mem_wr_req || mem_wr_addr !== last_wr_addr || mem_wr_data !== last_wr_data || cpu_addr_ok)
            stable_err++;
          if (wr_wait < wr_delay) wr_wait++;
          else begin mem_wr_ready = 1'b1; wr_phase = 2; end
        end
      end
    end
  end

  // Completion pulse counter.
  initial forever begin
    @(negedge clk);
    if (cpu_data_ok && !reset) dok_cnt++;
  end

  task automatic set_rf(input logic [31:0] base);
    for (int i = 0; i < 4; i++) rf_data[i] = base + 32'(i);
  endtask

  task automatic do_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    int ok_err;
    bit done;
    ok_err = 0; done = 1'b0; lat = 0; rdata = 32'h0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    #1 check_eq("addr_ok", cpu_addr_ok, 1'b1);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_addr_ok) ok_err++;
      if (cpu_data_ok) begin rdata = cpu_rdata; done = 1'b1; end
    end
    cpu_req = 1'b0;
    check_eq("data_ok_seen", done, 1'b1);
    check_eq("single_accept", ok_err, 0);
  endtask

  logic [31:0] rd;
  int          lat;
  bit          seen;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    set_rf(32'h0000_0AA0);
    repeat (3) @(negedge clk);
    check_eq("rst_addr_ok", cpu_addr_ok, 1'b0);
    check_eq("rst_data_ok", cpu_data_ok, 1'b0);
    check_eq("rst_rd_req", mem_rd_req, 1'b0);
    check_eq("rst_wr_req", mem_wr_req, 1'b0);
    check_eq("rst_ram_wen", ram_wen, 1'b0);
    reset = 1'b0;

    // Cold load miss, then a hit
    do_access(1'b0, 2'b10, 32'h0000_1004, 32'h0, rd, lat);
    check_eq("cold_rdata", rd, 32'h0000_0AA1);
    check_eq("cold_rd_addr", last_rd_addr, 32'h0000_1000);
    check_eq("cold_rd_cnt", rd_req_cnt, 1);
    do_access(1'b0, 2'b10, 32'h0000_1004, 32'h0, rd, lat);
    check_eq("hit_rdata", rd, 32'h0000_0AA1);
    check_eq("hit_lat", lat, 1);
    check_eq("hit_rd_cnt", rd_req_cnt, 1);

    // Byte store hit into lane 2
    do_access(1'b1, 2'b00, 32'h0000_1006, 32'h0000_005A, rd, lat);
    check_eq("stb_lat", lat, 1);
    do_access(1'b0, 2'b10, 32'h0000_1004, 32'h0, rd, lat);
    check_eq("stb_rdata", rd, 32'h005A_0AA1);
    check_eq("stb_no_bus", rd_req_cnt + wr_req_cnt, 1);

    // Conflict miss on a dirty line: writeback then refill
    set_rf(32'h0000_0BB0);
    do_access(1'b0, 2'b10, 32'h0000_2004, 32'h0, rd, lat);
    check_eq("wb_cnt", wr_req_cnt, 1);
    check_eq("wb_addr", last_wr_addr, 32'h0000_1000);
    check_eq("wb_data", last_wr_data, {32'h0000_0AA3, 32'h0000_0AA2, 32'h005A_0AA1, 32'h0000_0AA0});
    check_eq("wb_order", order_err, 0);
    check_eq("conf_rd_addr", last_rd_addr, 32'h0000_2000);
    check_eq("conf_rdata", rd, 32'h0000_0BB1);

    // Half store miss on a clean line
    set_rf(32'h1234_5670);
    do_access(1'b1, 2'b01, 32'h0000_3002, 32'h0000_BEEF, rd, lat);
    check_eq("sth_no_wb", wr_req_cnt, 1);
    check_eq("sth_rd_addr", last_rd_addr, 32'h0000_3000);
    do_access(1'b0, 2'b10, 32'h0000_3000, 32'h0, rd, lat);
    check_eq("sth_rdata", rd, 32'hBEEF_5670);

    // Writeback stalled by mem_wr_ready for 10 cycles
    set_rf(32'h0000_0DD0);
    wr_delay = 10;
    do_access(1'b0, 2'b10, 32'h0000_1000, 32'h0, rd, lat);
    wr_delay = 0;
    check_eq("stall_wb_addr", last_wr_addr, 32'h0000_3000);
    check_eq("stall_wb_data", last_wr_data, {32'h1234_5673, 32'h1234_5672, 32'h1234_5671, 32'hBEEF_5670});
    check_eq("stall_stable", stable_err, 0);
    check_eq("stall_rdata", rd, 32'h0000_0DD0);
    check_eq("stall_order", order_err, 0);

    // Reset in the middle of a refill
    set_rf(32'h0000_0CC0);
    rd_limit = 2;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h0000_5048;
    @(negedge clk);
    cpu_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #2;
      if (rd_phase == 2 && rd_beat == 2) seen = 1'b1;
    end
    check_eq("rst_two_beats", seen, 1'b1);
    check_eq("rst_rd_addr", last_rd_addr, 32'h0000_5040);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #2;
    check_eq("rst_mid_rd_req", mem_rd_req, 1'b0);
    check_eq("rst_mid_wen", ram_wen, 1'b0);
    check_eq("rst_mid_data_ok", cpu_data_ok, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_no_completion", dok_cnt, 8);
    rd_limit = 4;
    do_access(1'b0, 2'b10, 32'h0000_5048, 32'h0, rd, lat);
    check_eq("rst_remiss_cnt", rd_req_cnt, 6);
    check_eq("rst_rdata", rd, 32'h0000_0CC2);
    repeat (2) @(negedge clk);
    check_eq("total_data_ok", dok_cnt, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate controller for the L1 data cache.
- Owns the tag, valid and dirty arrays. Sequences the external line-wide data RAM: index, offset, byte position, write size, write data and write enable.
- Arbitrates between CPU load/store traffic, dirty-line writeback and line refill from the memory bus.
- Sits between the MEM pipeline stage and the bus bridge.

Parameters:
CACHE_S, 6, index bits; 2^CACHE_S lines
CACHE_B, 4, byte-offset bits; line = 2^CACHE_B bytes, WORDS = 2^(CACHE_B-2)
ADDR_WIDTH, 32, address width; tag = ADDR_WIDTH-CACHE_S-CACHE_B bits
LINE_W, 8*2^CACHE_B, line width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request
cpu_wr  in  1  1 = store
cpu_size  in  2  00 byte, 01 half, 10 word
cpu_addr  in  ADDR_WIDTH  byte address, naturally aligned
cpu_wdata  in  32  store data, right-justified
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  load data valid / store complete
cpu_rdata  out  32  load word (full aligned word)
ram_index  out  CACHE_S  data RAM line index
ram_offset  out  CACHE_B-2  word within line
ram_bit_pos  out  2  byte within word
ram_size  out  2  RAM write size; only 10 (word) is issued
ram_din  out  LINE_W  RAM write data; the word is replicated in every word slot
ram_wen  out  1  RAM write enable
ram_rdata  in  LINE_W  RAM combinational read of ram_index
mem_rd_req  out  1  refill request
mem_rd_addr  out  ADDR_WIDTH  line-aligned refill address
mem_rd_ready  in  1  refill request accepted
mem_rd_valid  in  1  refill beat valid
mem_rd_data  in  32  refill beat, word order 0..WORDS-1
mem_wr_req  out  1  writeback request
mem_wr_addr  out  ADDR_WIDTH  line-aligned victim address
mem_wr_data  out  LINE_W  victim line
mem_wr_ready  in  1  writeback accepted
mem_wr_done  in  1  writeback written to memory

Behaviour:
- Reset (clock clk; reset is synchronous, active-high):
  - state=IDLE; all valid and dirty bits cleared.
  - All outputs 0 except cpu_addr_ok, which follows the IDLE rule from the next cycle.
  - Reset mid-transaction aborts it; no completion pulse is issued.
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT.
- IDLE:
  - cpu_addr_ok = cpu_req (combinational).
  - On accept, latch addr/wr/size/wdata into a request register; go to LOOKUP.
- LOOKUP: ram_index and ram_offset come from the latched address. hit = valid[idx] and tag match.
  - Load hit: cpu_data_ok=1; cpu_rdata = ram_rdata word[offset]; go to IDLE.
  - Store hit:
    - ram_wen=1, ram_size=10.
    - Merged word = old word with the byte lanes selected by size and addr[1:0] replaced from cpu_wdata. Byte uses lane addr[1:0]; half uses lanes addr[1]*2 +: 2.
    - dirty[idx] set; cpu_data_ok=1; go to IDLE.
  - Miss: go to WB_REQ if valid and dirty, else RF_REQ.
- Hit latency: 1 cycle after accept; peak throughput 1 request per 2 cycles.
- WB_REQ:
  - mem_wr_req=1; mem_wr_addr = {old tag, idx, 0}; mem_wr_data = ram_rdata. All three are held stable until mem_wr_ready.
  - On mem_wr_ready go to WB_WAIT.
- WB_WAIT: on mem_wr_done, clear dirty[idx] and go to RF_REQ.
- RF_REQ:
  - valid[idx] cleared on entry.
  - mem_rd_req=1 with the line-aligned address.
  - On mem_rd_ready, clear beat counter cnt; go to RF_WAIT.
- RF_WAIT:
  - Each mem_rd_valid beat: ram_wen=1, ram_size=10, ram_offset=cnt, ram_din = beat replicated; cnt++.
  - On beat WORDS-1: tag[idx] = new tag, valid=1, dirty=0; go to LOOKUP (replay), which then hits.
  - cnt wraps only via the state exit.
- Completion ordering:
  - cpu_data_ok occurs exactly once per accepted request, always from LOOKUP.
  - cpu_addr_ok is 0 in every state other than IDLE; no second request is accepted while one is outstanding.
- Edge cases:
  - mem_rd_valid in any state other than RF_WAIT is ignored.
  - mem_wr_done outside WB_WAIT is ignored.
  - cpu_req dropping after cpu_addr_ok has no effect.

Test Plan:
- Cold load 0x0000_1004 after reset: miss, mem_rd_addr=0x0000_1000, 4 beats AA0..AA3 → cpu_data_ok with cpu_rdata=AA1. A repeat load hits in 1 cycle with no mem_rd_req.
- Store byte 0x5A to 0x0000_1006 on the resident line, then load 0x0000_1004 → returns AA1 with byte lane 2 = 5A; dirty set, no bus traffic.
- Conflicting load 0x0000_2004 (same index) after the dirty store:
  - mem_wr_req addr 0x0000_1000 carrying the merged line.
  - Refill issued only after mem_wr_done.
  - Load returns the new word 1.
- Store half 0xBEEF to 0x0000_3002 (miss, clean line): refill, then write → word = {BEEF, refilled low half}.
- mem_wr_ready held low 10 cycles: mem_wr_req and mem_wr_data stay stable, cpu_addr_ok stays 0.
- Reset asserted during RF_WAIT after 2 beats: next cycle state=IDLE, no cpu_data_ok. A subsequent load to the same line misses again.
